// File: rtl/negedge_generator_if.sv
// ============================================================================
// Module   : negedge_generator_if
// Brief    : Request/falling-edge bundle between a requester and the generator.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface negedge_generator_if #(
    parameter int MAX_PENDING = 7
);
    localparam int PW = $clog2(MAX_PENDING + 1);

    logic          req;
    logic          signal;
    logic          busy;
    logic [PW-1:0] pending;
    logic          done;
    logic          drop;

    modport master (
        output req,
        input  signal,
        input  busy,
        input  pending,
        input  done,
        input  drop
    );

    modport slave (
        input  req,
        output signal,
        output busy,
        output pending,
        output done,
        output drop
    );
endinterface

`default_nettype wire

// File: rtl/negedge_generator.sv
// ============================================================================
// Module   : negedge_generator
// Brief    : Turns request strobes into fixed-width low pulses on an idle-high
//            line, queueing overlapping requests up to MAX_PENDING.
// Revision : 1.0
// ============================================================================
`default_nettype none

module negedge_generator #(
    parameter int LOW_CYCLES  = 4,
    parameter int HIGH_CYCLES = 2,
    parameter int MAX_PENDING = 7
) (
    input  wire logic           clk,
    input  wire logic           rst,
    negedge_generator_if.slave  bus
);
    localparam int PW   = $clog2(MAX_PENDING + 1);
    localparam int TMAX = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [TW-1:0] c_low_load  = TW'(LOW_CYCLES - 1);
    localparam logic [TW-1:0] c_high_load = TW'(HIGH_CYCLES - 1);
    localparam logic [PW-1:0] c_max_pend  = PW'(MAX_PENDING);

    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [PW-1:0] r_pending;
    logic          r_signal;
    logic          r_done;
    logic          r_drop;

    logic w_has_work;
    logic w_start;

    assign w_has_work = bus.req || (r_pending != '0);
    // A pulse may begin from idle, or straight out of the final gap cycle.
    assign w_start    = w_has_work &&
                        ((r_state == IDLE) || ((r_state == GAP) && (r_timer == '0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_pending <= '0;
            r_signal  <= 1'b1;
            r_done    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_drop <= 1'b0;

            // A start consumes the live request first, else one queued request.
            if (w_start && !bus.req) begin
                r_pending <= r_pending - PW'(1);
            end else if (bus.req && !w_start) begin
                if (r_pending == c_max_pend) begin
                    r_drop <= 1'b1;
                end else begin
                    r_pending <= r_pending + PW'(1);
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state  <= LOW;
                        r_signal <= 1'b0;
                        r_timer  <= c_low_load;
                    end
                end
                LOW: begin
                    if (r_timer == '0) begin
                        r_state  <= GAP;
                        r_signal <= 1'b1;
                        r_done   <= 1'b1;
                        r_timer  <= c_high_load;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                GAP: begin
                    if (r_timer == '0) begin
                        if (w_start) begin
                            r_state  <= LOW;
                            r_signal <= 1'b0;
                            r_timer  <= c_low_load;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_signal <= 1'b1;
                    r_timer  <= '0;
                end
            endcase
        end
    end

    assign bus.signal  = r_signal;
    assign bus.pending = r_pending;
    assign bus.done    = r_done;
    assign bus.drop    = r_drop;
    assign bus.busy    = (r_state != IDLE) || (r_pending != '0);
endmodule

`default_nettype wire

// File: tb/tb_negedge_generator.sv
// ============================================================================
// Module   : tb_negedge_generator
// Brief    : Two generator configurations checked cycle by cycle against a
//            start-time / pending-count reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_negedge_generator;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    negedge_generator_if #(.MAX_PENDING(7)) if0 ();
    negedge_generator_if #(.MAX_PENDING(3)) if1 ();

    negedge_generator #(.LOW_CYCLES(4), .HIGH_CYCLES(2), .MAX_PENDING(7)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    negedge_generator #(.LOW_CYCLES(1), .HIGH_CYCLES(1), .MAX_PENDING(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    // Reference model: a pulse is fully described by the edge it started on.
    int c_low [2] = '{4, 1};
    int c_high[2] = '{2, 1};
    int c_max [2] = '{7, 3};
    int k;
    int m_s[2];
    int m_p[2];
    bit m_drop[2];
    int m_drops[2];
    int m_starts[2];

    int pass_cnt  = 0;
    int total_cnt = 0;

    int edges0 = 0, edges1 = 0, dones0 = 0, drops0 = 0;
    always @(negedge if0.signal) edges0++;
    always @(negedge if1.signal) edges1++;
    always @(posedge clk) begin
        if (if0.done === 1'b1) dones0++;
        if (if0.drop === 1'b1) drops0++;
    end

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s[i]    = -1000;
            m_p[i]    = 0;
            m_drop[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(int i, bit r);
        bit can_start;
        bit st;
        can_start = (k - m_s[i]) >= (c_low[i] + c_high[i]);
        st        = can_start && (r || (m_p[i] > 0));
        m_drop[i] = 1'b0;
        if (st) begin
            m_s[i] = k;
            m_starts[i]++;
            if (!r) m_p[i]--;
        end else if (r) begin
            if (m_p[i] == c_max[i]) begin
                m_drop[i] = 1'b1;
                m_drops[i]++;
            end else begin
                m_p[i]++;
            end
        end
    endfunction

    function automatic logic [6:0] exp_vec(int i);
        bit sig, dn, bsy;
        sig = !((k >= m_s[i]) && (k < m_s[i] + c_low[i]));
        dn  = (k == m_s[i] + c_low[i]);
        bsy = (k <= m_s[i] + c_low[i] + c_high[i] - 1) || (m_p[i] != 0);
        return {sig, bsy, 3'(m_p[i]), dn, m_drop[i]};
    endfunction

    function automatic logic [6:0] act_vec(int i);
        if (i == 0)
            return {if0.signal, if0.busy, 3'(if0.pending), if0.done, if0.drop};
        return {if1.signal, if1.busy, 3'(if1.pending), if1.done, if1.drop};
    endfunction

    task automatic tick(bit r0, bit r1);
        @(negedge clk);
        if0.req = r0;
        if1.req = r1;
        @(posedge clk);
        k++;
        model_edge(0, r0);
        model_edge(1, r1);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        if0.req = 1'b0;
        if1.req = 1'b0;
        k       = 0;
        m_drops  = '{0, 0};
        m_starts = '{0, 0};
        model_reset();
        #2 rst = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 2; i++) begin
                total_cnt++;
                if (act_vec(i) !== 7'b1000000)
                    $display("FAIL reset i%0d c%0d: got %b want %b", i, c, act_vec(i), 7'b1000000);
                else pass_cnt++;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int e0;
        e0 = edges0;
        for (int c = 0; c < 4; c++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        total_cnt++;
        if (if0.signal !== 1'b0) $display("FAIL single_latency: got %b want 0", if0.signal);
        else pass_cnt++;
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                total_cnt++;
                if (act_vec(i) !== exp_vec(i))
                    $display("FAIL single i%0d c%0d: got %b want %b", i, c, act_vec(i), exp_vec(i));
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (edges0 - e0 !== 1) $display("FAIL single_edges: got %0d want 1", edges0 - e0);
        else pass_cnt++;
    endtask

    task automatic test_burst3();
        int d0, dr0;
        d0  = dones0;
        dr0 = drops0;
        for (int c = 0; c < 25; c++) begin
            tick(c < 3, 1'b0);
            for (int i = 0; i < 2; i++) begin
                total_cnt++;
                if (act_vec(i) !== exp_vec(i))
                    $display("FAIL burst3 i%0d c%0d: got %b want %b", i, c, act_vec(i), exp_vec(i));
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (dones0 - d0 !== 3) $display("FAIL burst3_done: got %0d want 3", dones0 - d0);
        else pass_cnt++;
        total_cnt++;
        if (drops0 - dr0 !== 0) $display("FAIL burst3_drop: got %0d want 0", drops0 - dr0);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        int e0, md0, maxp;
        e0   = edges0;
        md0  = m_drops[0];
        maxp = 0;
        for (int c = 0; c < 70; c++) begin
            tick(c < 12, 1'b0);
            if (int'(if0.pending) > maxp) maxp = int'(if0.pending);
            for (int i = 0; i < 2; i++) begin
                total_cnt++;
                if (act_vec(i) !== exp_vec(i))
                    $display("FAIL saturate i%0d c%0d: got %b want %b", i, c, act_vec(i), exp_vec(i));
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (maxp !== 7) $display("FAIL saturate_peak: got %0d want 7", maxp);
        else pass_cnt++;
        total_cnt++;
        if (edges0 - e0 !== 12 - (m_drops[0] - md0))
            $display("FAIL saturate_edges: got %0d want %0d", edges0 - e0, 12 - (m_drops[0] - md0));
        else pass_cnt++;
    endtask

    task automatic test_gap_arrival();
        for (int c = 0; c < 13; c++) tick((c < 4) || (c == 12), 1'b0);
        total_cnt++;
        if ({if0.signal, if0.pending} !== {1'b0, 3'd2})
            $display("FAIL gap_arrival: got sig=%b pend=%0d want sig=0 pend=2", if0.signal, if0.pending);
        else pass_cnt++;
        for (int c = 0; c < 30; c++) begin
            tick(1'b0, 1'b0);
            total_cnt++;
            if (act_vec(0) !== exp_vec(0))
                $display("FAIL gap_drain c%0d: got %b want %b", c, act_vec(0), exp_vec(0));
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        int e0;
        for (int c = 0; c < 8; c++) tick(c < 5, 1'b0);
        total_cnt++;
        if ({if0.signal, if0.pending} !== {1'b0, 3'd3})
            $display("FAIL areset_pre: got sig=%b pend=%0d want sig=0 pend=3", if0.signal, if0.pending);
        else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        model_reset();
        total_cnt++;
        if (act_vec(0) !== 7'b1000000)
            $display("FAIL areset_now: got %b want %b", act_vec(0), 7'b1000000);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        e0  = edges0;
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, 1'b0);
            total_cnt++;
            if (act_vec(0) !== exp_vec(0))
                $display("FAIL areset_after c%0d: got %b want %b", c, act_vec(0), exp_vec(0));
            else pass_cnt++;
        end
        total_cnt++;
        if (edges0 - e0 !== 0) $display("FAIL areset_edges: got %0d want 0", edges0 - e0);
        else pass_cnt++;
    endtask

    task automatic test_fast();
        int e1, s1;
        e1 = edges1;
        s1 = m_starts[1];
        for (int c = 0; c < 35; c++) begin
            tick(1'b0, c < 20);
            total_cnt++;
            if (act_vec(1) !== exp_vec(1))
                $display("FAIL fast c%0d: got %b want %b", c, act_vec(1), exp_vec(1));
            else pass_cnt++;
        end
        total_cnt++;
        if (edges1 - e1 !== m_starts[1] - s1)
            $display("FAIL fast_edges: got %0d want %0d", edges1 - e1, m_starts[1] - s1);
        else pass_cnt++;
    endtask

    task automatic test_random();
        bit r0, r1;
        for (int c = 0; c < 370; c++) begin
            r0 = (c < 300) && ($urandom_range(0, 3) == 0);
            r1 = (c < 300) && ($urandom_range(0, 1) == 0);
            tick(r0, r1);
            for (int i = 0; i < 2; i++) begin
                total_cnt++;
                if (act_vec(i) !== exp_vec(i))
                    $display("FAIL random i%0d c%0d: got %b want %b", i, c, act_vec(i), exp_vec(i));
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst3();
        test_saturate();
        test_gap_arrival();
        test_async_reset();
        test_fast();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

`default_nettype wire
